digit_scan_driver: RTL and testbench

//  Time-multiplexed N-digit display scanner; parametrised successor to the 3-digit select decoder.

---
 rtl/digit_scan_driver.sv | 216 +++++++++++++++++++++
 tb/tb_digit_scan_driver.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_scan_driver.sv
// ----------------------------------------------------------------------------
// digit_scan_driver
//
// Time-multiplexed N-digit display scanner. It takes a packed vector of digit
// codes from the counter/BCD logic and drives one digit at a time for a fixed
// dwell. The enables are one-hot, active-low, and an all-off blanking gap sits
// between digits to hide ghosting. The digit code is passed on to a 7-segment
// encoder. Leading zeros can be blanked without changing the frame timing.
//
// The input vector is captured once per frame, so a value that changes mid-scan
// never shows half old and half new digits.
//
// Parameters
//   NUM_DIGITS    digits scanned (index 0 = ones); at least 2
//   DIGIT_W       bits per digit code
//   REFRESH_DIV   clk cycles each digit is driven; at least 1
//   BLANK_CYCLES  clk cycles of all-off gap between digits; 0 = no gap
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   en           scan enable; low = display dark, scanner idle
//   lz_suppress  1 = blank leading zero digits (digit 0 always shown)
//   digits_in    digit i at [i*DIGIT_W +: DIGIT_W]
//   digit_en_n   active-low digit enables, at most one bit low
//   digit_val    code of the currently enabled digit
//   digit_idx    index of the current (or, during a gap, just-finished) digit
//   frame_done   one-cycle pulse when a full scan wraps back to digit 0
// ----------------------------------------------------------------------------
module digit_scan_driver #(
  parameter  int NUM_DIGITS   = 3,
  parameter  int DIGIT_W      = 4,
  parameter  int REFRESH_DIV  = 100000,
  parameter  int BLANK_CYCLES = 16,
  localparam int IDX_W        = $clog2(NUM_DIGITS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          lz_suppress,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] digits_in,
  output logic [NUM_DIGITS-1:0]         digit_en_n,
  output logic [DIGIT_W-1:0]            digit_val,
  output logic [IDX_W-1:0]              digit_idx,
  output logic                          frame_done
);

  // One counter serves both the dwell and the gap, so it is sized for the
  // longer of the two and is always cleared on entry to either phase.
  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam int B_LAST_I = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;

  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(B_LAST_I);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_GAP
  } state_t;

  typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digit_vec_t;

  // Registered state
  state_t             state;
  logic [CNT_W-1:0]   cnt;
  digit_vec_t         snap;

  // Next-state values
  state_t             state_next;
  logic [CNT_W-1:0]   cnt_next;
  digit_vec_t         snap_next;
  logic [IDX_W-1:0]   idx_next;
  logic               frame_next;
  logic               step;

  // Next-output values
  logic [NUM_DIGITS-1:0] zero_from;
  logic                  run;
  logic                  suppress;
  logic [NUM_DIGITS-1:0] en_n_next;
  logic [DIGIT_W-1:0]    val_next;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; a missing default here would infer a latch.
    state_next = state;
    cnt_next   = cnt;
    snap_next  = snap;
    idx_next   = digit_idx;
    frame_next = 1'b0;
    step       = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (en) begin
          state_next = S_DRIVE;
          snap_next  = digits_in;
          idx_next   = '0;
          cnt_next   = '0;
        end
      end

      S_DRIVE: begin
        if (cnt == DRIVE_LAST) begin
          if (BLANK_CYCLES > 0) begin
            state_next = S_GAP;
            cnt_next   = '0;
          end else begin
            step = 1'b1;
          end
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end

      S_GAP: begin
        if (cnt == GAP_LAST) begin
          step = 1'b1;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end

      default: state_next = S_IDLE;
    endcase

    // Move on to the next digit; wrapping past the last digit starts a new
    // frame, which is the only point where the input vector is captured.
    if (step) begin
      state_next = S_DRIVE;
      cnt_next   = '0;
      if (digit_idx == LAST_IDX) begin
        idx_next   = '0;
        snap_next  = digits_in;
        frame_next = 1'b1;
      end else begin
        idx_next = digit_idx + IDX_W'(1);
      end
    end

    // Dropping the enable overrides any transition computed above.
    if (!en) begin
      state_next = S_IDLE;
      idx_next   = '0;
      cnt_next   = '0;
      frame_next = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Next-output logic, computed from the next state so outputs are registered
  // and line up with the state they describe.
  // --------------------------------------------------------------------------
  always_comb begin
    // zero_from[i] is set when digits i..NUM_DIGITS-1 of the frame are all zero.
    zero_from = '0;
    run       = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run          = run & (snap_next[i] == '0);
      zero_from[i] = run;
    end

    // A suppressed digit keeps its time slot with the enables all off, so the
    // brightness of the remaining digits does not depend on the value shown.
    suppress = lz_suppress && (idx_next != '0) && zero_from[idx_next];

    en_n_next = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((state_next == S_DRIVE) && !suppress && (idx_next == IDX_W'(i))) begin
        en_n_next[i] = 1'b0;
      end
    end

    val_next = (state_next == S_IDLE) ? '0 : snap_next[idx_next];
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      // NOTE: the snapshot is a small register bank, not a RAM, so resetting
      // it is cheap and keeps digit_val well defined after reset.
      snap       <= '0;
      digit_idx  <= '0;
      digit_en_n <= '1;
      digit_val  <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      snap       <= snap_next;
      digit_idx  <= idx_next;
      digit_en_n <= en_n_next;
      digit_val  <= val_next;
      frame_done <= frame_next;
    end
  end

  // Two digits lit at once would short segment drivers through the common pin.
  one_enable_max: assert property (
    @(posedge clk) disable iff (!rst_n) $countones(~digit_en_n) <= 1
  );

endmodule

// File: tb/tb_digit_scan_driver.sv
// ----------------------------------------------------------------------------
// tb_digit_scan_driver
//
// Two scanners: "a" with a 2-cycle blanking gap and "b" with no gap, both
// 3 digits x 4 bits with a 4-cycle dwell. Stimulus pushes one expected record
// per clock cycle into a queue; a monitor per instance pops one record on every
// falling edge while its queue is non-empty and compares it with the outputs.
// ----------------------------------------------------------------------------
module tb_digit_scan_driver;

  localparam int ND = 3;
  localparam int DW = 4;
  localparam int RD = 4;
  localparam int BC = 2;

  typedef struct {
    logic [ND-1:0] en_n;
    logic [DW-1:0] val;
    logic [1:0]    idx;
    logic          fd;
    string         tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  logic          a_en, a_lz;
  logic [11:0]   a_dig;
  logic [ND-1:0] a_en_n;
  logic [DW-1:0] a_val;
  logic [1:0]    a_idx;
  logic          a_fd;

  logic          b_en, b_lz;
  logic [11:0]   b_dig;
  logic [ND-1:0] b_en_n;
  logic [DW-1:0] b_val;
  logic [1:0]    b_idx;
  logic          b_fd;

  exp_t q_a[$];
  exp_t q_b[$];

  int n_checks = 0;
  int n_fail   = 0;
  string cur_tag = "reset";

  always #5 clk = ~clk;

  digit_scan_driver #(
    .NUM_DIGITS(ND), .DIGIT_W(DW), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .en(a_en), .lz_suppress(a_lz), .digits_in(a_dig),
    .digit_en_n(a_en_n), .digit_val(a_val), .digit_idx(a_idx), .frame_done(a_fd)
  );

  digit_scan_driver #(
    .NUM_DIGITS(ND), .DIGIT_W(DW), .REFRESH_DIV(RD), .BLANK_CYCLES(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .en(b_en), .lz_suppress(b_lz), .digits_in(b_dig),
    .digit_en_n(b_en_n), .digit_val(b_val), .digit_idx(b_idx), .frame_done(b_fd)
  );

  // --------------------------------------------------------------------------
  // Checking helpers
  // --------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic compare_rec(input bit which, input exp_t e);
    logic [ND-1:0] en_n;
    logic [DW-1:0] v;
    logic [1:0]    ix;
    logic          f;
    string         p;
    if (which) begin
      en_n = b_en_n; v = b_val; ix = b_idx; f = b_fd; p = "b";
    end else begin
      en_n = a_en_n; v = a_val; ix = a_idx; f = a_fd; p = "a";
    end
    check($sformatf("%s.%s.en_n", p, e.tag), 32'(en_n), 32'(e.en_n));
    check($sformatf("%s.%s.idx", p, e.tag), 32'(ix), 32'(e.idx));
    check($sformatf("%s.%s.frame_done", p, e.tag), 32'(f), 32'(e.fd));
    if (e.en_n != '1)
      check($sformatf("%s.%s.val", p, e.tag), 32'(v), 32'(e.val));
  endtask

  task automatic check_reset(input bit which, input string name);
    exp_t e;
    e.en_n = '1; e.val = '0; e.idx = '0; e.fd = 1'b0; e.tag = name;
    compare_rec(which, e);
    // Reset forces digit_val to 0 even where the record skips it.
    check($sformatf("%s.val_rst", name), which ? 32'(b_val) : 32'(a_val), 32'd0);
  endtask

  // Scoreboard monitors
  always @(negedge clk) begin
    if (q_a.size() > 0) compare_rec(1'b0, q_a.pop_front());
  end

  always @(negedge clk) begin
    if (q_b.size() > 0) compare_rec(1'b1, q_b.pop_front());
  end

  // At most one enable low, every cycle, both instances.
  always @(negedge clk) begin
    if (rst_n) begin
      check("a.one_hot", 32'($countones(~a_en_n) <= 1), 32'd1);
      check("b.one_hot", 32'($countones(~b_en_n) <= 1), 32'd1);
    end
  end

  // --------------------------------------------------------------------------
  // Expectation builders
  // --------------------------------------------------------------------------
  task automatic push(input bit which, input logic [ND-1:0] en_n, input logic [DW-1:0] val,
                      input logic [1:0] idx, input logic fd);
    exp_t e;
    e.en_n = en_n; e.val = val; e.idx = idx; e.fd = fd; e.tag = cur_tag;
    if (which) q_b.push_back(e);
    else       q_a.push_back(e);
  endtask

  task automatic push_idle(input bit which);
    push(which, 3'b111, 4'h0, 2'd0, 1'b0);
  endtask

  // One digit slot: n_drive cycles lit (or dark if suppressed), n_gap dark.
  task automatic push_slot(input bit which, input int k, input logic [11:0] d, input logic sup,
                           input int n_drive, input int n_gap, input logic fd_first);
    logic [ND-1:0] oh;
    logic [DW-1:0] dv;
    oh    = '1;
    oh[k] = sup;
    dv    = d[k*DW +: DW];
    for (int c = 0; c < n_drive; c++)
      push(which, oh, dv, 2'(k), fd_first && (c == 0));
    for (int c = 0; c < n_gap; c++)
      push(which, 3'b111, dv, 2'(k), 1'b0);
  endtask

  task automatic push_frame(input bit which, input logic [11:0] d, input logic [2:0] sup,
                            input logic fd_first);
    int gap;
    gap = which ? 0 : BC;
    for (int k = 0; k < ND; k++)
      push_slot(which, k, d, sup[k], RD, gap, fd_first && (k == 0));
  endtask

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic drive_in(input bit which, input logic en, input logic [11:0] d, input logic lz);
    if (which) begin b_en = en; b_dig = d; b_lz = lz; end
    else       begin a_en = en; a_dig = d; a_lz = lz; end
  endtask

  // Scanner must be idle on entry; the first pushed record is that idle cycle.
  task automatic start_scan(input bit which, input logic [11:0] d, input logic lz);
    @(posedge clk);
    #1;
    drive_in(which, 1'b1, d, lz);
    push_idle(which);
  endtask

  task automatic drain(input bit which);
    int n;
    n = 0;
    while (((which ? q_b.size() : q_a.size()) > 0) && (n < 500)) begin
      @(negedge clk);
      n++;
    end
    if ((which ? q_b.size() : q_a.size()) > 0) begin
      check("drain_timeout", 32'(which ? q_b.size() : q_a.size()), 32'd0);
      if (which) q_b.delete();
      else       q_a.delete();
    end
  endtask

  task automatic stop(input bit which);
    drain(which);
    @(posedge clk);
    #1;
    if (which) b_en = 1'b0;
    else       a_en = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin
    rst_n = 1'b0;
    drive_in(1'b0, 1'b0, 12'h000, 1'b0);
    drive_in(1'b1, 1'b0, 12'h000, 1'b0);

    #12;
    check_reset(1'b0, "a.reset");
    check_reset(1'b1, "b.reset");
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Basic scan of 321, then a mid-frame change to 987 that must wait for
    // the following frame.
    cur_tag = "s1_scan";
    start_scan(1'b0, 12'h321, 1'b0);
    push_frame(1'b0, 12'h321, 3'b000, 1'b0);
    push_frame(1'b0, 12'h321, 3'b000, 1'b1);
    cur_tag = "s2_snapshot";
    push_frame(1'b0, 12'h987, 3'b000, 1'b1);
    repeat (25) @(posedge clk);
    #1 a_dig = 12'h987;
    stop(1'b0);

    // Leading-zero suppression.
    cur_tag = "s3_lz005";
    start_scan(1'b0, 12'h005, 1'b1);
    push_frame(1'b0, 12'h005, 3'b110, 1'b0);
    push_frame(1'b0, 12'h005, 3'b110, 1'b1);
    stop(1'b0);

    cur_tag = "s3_lz000";
    start_scan(1'b0, 12'h000, 1'b1);
    push_frame(1'b0, 12'h000, 3'b110, 1'b0);
    stop(1'b0);

    cur_tag = "s3_lz050";
    start_scan(1'b0, 12'h050, 1'b1);
    push_frame(1'b0, 12'h050, 3'b100, 1'b0);
    push_frame(1'b0, 12'h050, 3'b100, 1'b1);
    stop(1'b0);

    // Enable dropped during digit-1 dwell, then raised with new digits.
    cur_tag = "s4_en_drop";
    start_scan(1'b0, 12'h321, 1'b0);
    push_slot(1'b0, 0, 12'h321, 1'b0, RD, BC, 1'b0);
    push_slot(1'b0, 1, 12'h321, 1'b0, 2, 0, 1'b0);
    push_idle(1'b0);
    push_idle(1'b0);
    cur_tag = "s4_restart";
    push_frame(1'b0, 12'h654, 3'b000, 1'b0);
    push(1'b0, 3'b110, 4'h4, 2'd0, 1'b1);
    repeat (8) @(posedge clk);
    #1 a_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 begin a_en = 1'b1; a_dig = 12'h654; end
    stop(1'b0);

    // Asynchronous reset in the middle of the digit-1 gap.
    cur_tag = "s5_pre_rst";
    start_scan(1'b0, 12'h321, 1'b0);
    push_slot(1'b0, 0, 12'h321, 1'b0, RD, BC, 1'b0);
    push_slot(1'b0, 1, 12'h321, 1'b0, RD, 0, 1'b0);
    repeat (11) @(posedge clk);
    #2 check("a.s5.gap_idx", 32'(a_idx), 32'd1);
    check("a.s5.gap_en_n", 32'(a_en_n), 32'h7);
    #1 rst_n = 1'b0;
    #1 check_reset(1'b0, "a.s5_async_rst");
    a_dig = 12'h654;
    @(posedge clk);
    #3 rst_n = 1'b1;
    cur_tag = "s5_restart";
    push_idle(1'b0);
    push_frame(1'b0, 12'h654, 3'b000, 1'b0);
    push(1'b0, 3'b110, 4'h4, 2'd0, 1'b1);
    stop(1'b0);

    // No-gap variant: digits back to back, 12-cycle frame.
    cur_tag = "s6_nogap";
    start_scan(1'b1, 12'h321, 1'b0);
    push_frame(1'b1, 12'h321, 3'b000, 1'b0);
    push_frame(1'b1, 12'h321, 3'b000, 1'b1);
    push(1'b1, 3'b110, 4'h1, 2'd0, 1'b1);
    stop(1'b1);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
